lea_key_sched: RTL

LEA_KEY_SCHED -- requirements
Module: lea_key_sched

---
 rtl/lea_pkg.sv | 41 ++++
 rtl/lea_ks_round.sv | 91 +++++++++
 rtl/lea_key_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lea_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lea_pkg
//  Purpose  : Shared constants for the LEA key schedule: the key-mode
//             encoding, the delta table, the per-word rotation amounts, the
//             round-count (NR) table and the 32-bit rotate helper.
//  Revision : 1.0 - initial release
// ============================================================================
package lea_pkg;

    // Key-mode encoding on the mode input
    localparam logic [1:0] c_mode_128 = 2'd0;
    localparam logic [1:0] c_mode_192 = 2'd1;
    localparam logic [1:0] c_mode_256 = 2'd2;
    localparam logic [1:0] c_mode_bad = 2'd3;

    // Round constants; round i uses c_delta[i mod M], M = 4/6/8 by mode
    localparam logic [31:0] c_delta [0:7] = '{
        32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
        32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957
    };

    // Left-rotate amount applied to the j-th updated word of a round
    localparam logic [4:0] c_rot [0:5] = '{
        5'd1, 5'd3, 5'd6, 5'd11, 5'd13, 5'd17
    };

    // Number of rounds per mode, indexed by the mode encoding (3 = illegal)
    localparam logic [5:0] c_nr [0:3] = '{
        6'd24, 6'd28, 6'd32, 6'd0
    };

    // 32-bit rotate left; the upper half of {x,x} << s is exactly ROL(x, s)
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] w_dbl;
        w_dbl = {x, x} << s;
        return w_dbl[63:32];
    endfunction

endpackage : lea_pkg
`default_nettype wire

// File: rtl/lea_ks_round.sv
`default_nettype none
// ============================================================================
//  Module   : lea_ks_round
//  Purpose  : One LEA key-schedule round, purely combinational. Takes the
//             current key state T[0..7], the round index and the key mode,
//             and returns the updated state plus the 192-bit round key.
//  Ports    : i_t    [7:0][31:0] current state, word n = T[n]
//             i_idx  [4:0]       round index i
//             i_mode [1:0]       key mode (0=128, 1=192, 2=256)
//             o_t    [7:0][31:0] next state
//             o_rk   [5:0][31:0] round key, word n = rk word n
//  Revision : 1.0 - initial release
// ============================================================================
module lea_ks_round
    import lea_pkg::*;
(
    input  logic [7:0][31:0] i_t,
    input  logic [4:0]       i_idx,
    input  logic [1:0]       i_mode,
    output logic [7:0][31:0] o_t,
    output logic [5:0][31:0] o_rk
);

    logic [2:0]       w_didx;
    logic [31:0]      w_delta;
    logic [5:0][31:0] w_dr;
    logic [2:0]       w_kbase;

    // Delta index i mod M; M depends on the mode
    always_comb begin
        w_didx = 3'd0;
        case (i_mode)
            c_mode_128: w_didx = {1'b0, i_idx[1:0]};
            c_mode_192: w_didx = 3'(i_idx % 5'd6);
            c_mode_256: w_didx = i_idx[2:0];
            default:    w_didx = 3'd0;
        endcase
    end

    assign w_delta = c_delta[w_didx];

    // ROL(d, i+j) for j = 0..5; the 5-bit sum wraps mod 32 as required
    always_comb begin
        w_dr = '0;
        for (int j = 0; j < 6; j++) begin
            w_dr[j] = rol32(w_delta, i_idx + 5'(j));
        end
    end

    // Starting word for the 256-bit mode: 6*i mod 8 = (2i + 4i) mod 8
    assign w_kbase = 3'({i_idx, 1'b0} + {i_idx, 2'b00});

    always_comb begin
        logic [2:0]  v_k;
        logic [31:0] v_w;
        o_t  = i_t;
        o_rk = '0;
        v_k  = 3'd0;
        v_w  = 32'd0;
        case (i_mode)
            c_mode_128: begin
                for (int j = 0; j < 4; j++) begin
                    o_t[j] = rol32(i_t[j] + w_dr[j], c_rot[j]);
                end
                // Word order 0..5 = T0, T1, T2, T1, T3, T1
                o_rk = {o_t[1], o_t[3], o_t[1], o_t[2], o_t[1], o_t[0]};
            end
            c_mode_192: begin
                for (int j = 0; j < 6; j++) begin
                    o_t[j]  = rol32(i_t[j] + w_dr[j], c_rot[j]);
                    o_rk[j] = o_t[j];
                end
            end
            c_mode_256: begin
                // Six consecutive words mod 8 never collide within one round
                for (int j = 0; j < 6; j++) begin
                    v_k      = w_kbase + 3'(j);
                    v_w      = rol32(i_t[v_k] + w_dr[j], c_rot[j]);
                    o_t[v_k] = v_w;
                    o_rk[j]  = v_w;
                end
            end
            default: begin
                o_t  = i_t;
                o_rk = '0;
            end
        endcase
    end

endmodule : lea_ks_round
`default_nettype wire

// File: rtl/lea_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : lea_key_sched
//  Purpose  : LEA key scheduler. On a start with a legal mode it latches the
//             key and mode, then streams NR round keys over a valid/ready
//             handshake, one per cycle when the consumer is always ready.
//  Ports    : clk       clock, rising edge
//             rst_n     asynchronous active-low reset
//             start     request a new schedule (honoured only when idle)
//             mode[1:0] 0=128-bit, 1=192-bit, 2=256-bit, 3=illegal
//             key[255:0] word n = key[32n+31:32n]
//             rk[191:0] current round key, word n at [32n+31:32n]
//             rk_idx[4:0] round index of rk
//             rk_valid  rk / rk_idx valid
//             rk_ready  consumer accepts rk
//             busy      high while not idle
//             done      one-cycle pulse after the last key is accepted
//             err       one-cycle pulse when start carries an illegal mode
//  Revision : 1.0 - initial release
// ============================================================================
module lea_key_sched
    import lea_pkg::*;
#(
    parameter bit ENABLE_192 = 1'b1,
    parameter bit ENABLE_256 = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [255:0] key,
    output logic [191:0] rk,
    output logic [4:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_out  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [7:0][31:0] r_t;

    logic             w_legal;
    logic             w_last;
    logic [4:0]       w_round_idx;
    logic [7:0][31:0] w_t_nxt;
    logic [5:0][31:0] w_rk_nxt;

    always_comb begin
        w_legal = 1'b0;
        case (mode)
            c_mode_128: w_legal = 1'b1;
            c_mode_192: w_legal = ENABLE_192;
            c_mode_256: w_legal = ENABLE_256;
            default:    w_legal = 1'b0;
        endcase
    end

    // LOAD produces round 0; in OUT the round engine always looks one ahead
    assign w_round_idx = (r_state == c_st_load) ? 5'd0 : rk_idx + 5'd1;
    assign w_last      = ({1'b0, rk_idx} == (c_nr[r_mode] - 6'd1));

    lea_ks_round u_round (
        .i_t    (r_t),
        .i_idx  (w_round_idx),
        .i_mode (r_mode),
        .o_t    (w_t_nxt),
        .o_rk   (w_rk_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_mode   <= 2'd0;
            r_t      <= '0;
            rk       <= '0;
            rk_idx   <= 5'd0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (w_legal) begin
                            r_mode  <= mode;
                            r_t     <= key;
                            busy    <= 1'b1;
                            r_state <= c_st_load;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                c_st_load: begin
                    rk       <= w_rk_nxt;
                    rk_idx   <= 5'd0;
                    rk_valid <= 1'b1;
                    r_t      <= w_t_nxt;
                    r_state  <= c_st_out;
                end
                c_st_out: begin
                    if (rk_ready) begin
                        if (w_last) begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            r_state  <= c_st_idle;
                        end else begin
                            rk     <= w_rk_nxt;
                            rk_idx <= w_round_idx;
                            r_t    <= w_t_nxt;
                        end
                    end
                end
                default: begin
                    rk_valid <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

endmodule : lea_key_sched
`default_nettype wire
